// File: rtl/tl_rr_arbiter.sv
// Two-requester round-robin front end for a single TileLink-UL A/D channel pair.
// One transaction in flight at a time; D responses are routed back to the granted owner.
module tl_rr_arbiter #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_wr,
  input  logic [1:0]          req_rd,
  input  logic [7:0]          req_byte,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_v,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [3:0]          a_opcode,
  output logic [3:0]          a_mask,
  output logic [ADDR_W-1:0]   a_address,
  output logic [DATA_W-1:0]   a_data,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [3:0]          d_opcode,
  input  logic [DATA_W-1:0]   d_data
);

  typedef enum logic [1:0] {StIdle, StSendA, StWaitD, StDone} state_e;

  localparam logic [3:0] OpPutFull       = 4'h0;
  localparam logic [3:0] OpPutPartial    = 4'h1;
  localparam logic [3:0] OpGet           = 4'h4;
  localparam logic [3:0] OpAccessAck     = 4'h0;
  localparam logic [3:0] OpAccessAckData = 4'h1;
  localparam logic [7:0] TimeoutCnt      = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                is_get_q, is_get_d;
  logic                last_gnt_q, last_gnt_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                a_valid_q, a_valid_d;
  logic [3:0]          a_opcode_q, a_opcode_d;
  logic [3:0]          a_mask_q, a_mask_d;
  logic [ADDR_W-1:0]   a_address_q, a_address_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic                d_ready_q, d_ready_d;
  logic [1:0]          rsp_v_q, rsp_v_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  // Grant selection and the granted requester's fields
  logic [1:0]          pending;
  logic                gnt;
  logic                sel_wr;
  logic [3:0]          sel_byte;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [7:0]          cnt_inc;

  always_comb begin
    pending   = req_wr | req_rd;
    gnt       = (&pending) ? ~last_gnt_q : pending[1];
    sel_wr    = gnt ? req_wr[1] : req_wr[0];
    sel_byte  = gnt ? req_byte[7:4] : req_byte[3:0];
    sel_addr  = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    cnt_inc   = cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_get_d    = is_get_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_mask_d    = a_mask_q;
    a_address_d = a_address_q;
    a_data_d    = a_data_q;
    d_ready_d   = d_ready_q;
    rsp_v_d     = rsp_v_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          owner_d     = gnt;
          is_get_d    = ~sel_wr;
          a_valid_d   = 1'b1;
          a_mask_d    = sel_byte;
          a_address_d = sel_addr;
          // Write wins when both wr and rd are raised
          if (sel_wr) begin
            a_opcode_d = (sel_byte == 4'hF) ? OpPutFull : OpPutPartial;
            a_data_d   = sel_wdata;
          end else begin
            a_opcode_d = OpGet;
            a_data_d   = '0;
          end
          state_d = StSendA;
        end
      end

      StSendA: begin
        if (a_ready) begin
          a_valid_d   = 1'b0;
          a_opcode_d  = '0;
          a_mask_d    = '0;
          a_address_d = '0;
          a_data_d    = '0;
          d_ready_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StWaitD;
        end
      end

      StWaitD: begin
        cnt_d = cnt_inc;
        // A response arriving on the timeout cycle still takes priority
        if (d_valid) begin
          rsp_data_d = is_get_q ? d_data : '0;
          rsp_err_d  = d_opcode != (is_get_q ? OpAccessAckData : OpAccessAck);
          rsp_v_d    = owner_q ? 2'b10 : 2'b01;
          d_ready_d  = 1'b0;
          state_d    = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_v_d    = owner_q ? 2'b10 : 2'b01;
          d_ready_d  = 1'b0;
          state_d    = StDone;
        end
      end

      StDone: begin
        rsp_v_d    = '0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        last_gnt_d = owner_q;
        cnt_d      = '0;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      is_get_q    <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_mask_q    <= '0;
      a_address_q <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
      rsp_v_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_get_q    <= is_get_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_mask_q    <= a_mask_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
      d_ready_q   <= d_ready_d;
      rsp_v_q     <= rsp_v_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_v     = rsp_v_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_mask    = a_mask_q;
  assign a_address = a_address_q;
  assign a_data    = a_data_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Bench for tl_rr_arbiter: directed vector table, reset/alternation sequences and
// randomized transactions checked against a transaction-level model.
module tb_tl_rr_arbiter;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_wr, req_rd;
  logic [7:0]          req_byte;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_v;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err, busy;
  logic                a_valid, a_ready;
  logic [3:0]          a_opcode, a_mask;
  logic [ADDR_W-1:0]   a_address;
  logic [DATA_W-1:0]   a_data;
  logic                d_valid, d_ready;
  logic [3:0]          d_opcode;
  logic [DATA_W-1:0]   d_data;

  tl_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_wr(req_wr), .req_rd(req_rd), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_v(rsp_v), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_data(d_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          who;
    logic        wr, rd;
    logic [3:0]  byt, addr;
    logic [31:0] wdata;
    int          a_dly, lat;
    logic [3:0]  d_op;
    logic [31:0] d_dat;
    logic [3:0]  e_op, e_mask;
    logic [31:0] e_adata, e_rdata;
    logic        e_err;
    bit          drop;
  } vec_t;

  typedef struct {
    bit          act;
    logic        wr, rd;
    logic [3:0]  byt, addr;
    logic [31:0] wd;
  } req_t;

  vec_t tbl[7];
  req_t rq[2];
  int   mdl_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic rd, input logic [3:0] b,
                         input logic [3:0] a, input logic [31:0] d);
    req_wr[i]             = wr;
    req_rd[i]             = rd;
    req_byte[i*4 +: 4]    = b;
    req_addr[i*4 +: 4]    = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_a_valid"}, 32'(a_valid), 32'd0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, "_rsp_v"}, 32'(rsp_v), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_wr = '0; req_rd = '0; a_ready = 1'b0; d_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Requests must already be driven and the DUT idle. Completes one transaction.
  task automatic run_txn(input int who, input logic [3:0] e_op, input logic [3:0] e_mask,
                         input logic [3:0] e_addr, input logic [31:0] e_adata,
                         input int a_dly, input int lat, input logic [3:0] d_op,
                         input logic [31:0] d_dat, input logic [31:0] e_rdata,
                         input logic e_err, input bit drop);
    int cyc;
    int e_cyc;
    tick();
    chk("a_valid_rise", 32'(a_valid), 32'd1);
    chk("busy_set", 32'(busy), 32'd1);
    chk("a_opcode", 32'(a_opcode), 32'(e_op));
    chk("a_mask", 32'(a_mask), 32'(e_mask));
    chk("a_address", 32'(a_address), 32'(e_addr));
    chk("a_data", a_data, e_adata);
    for (int k = 0; k < a_dly; k++) begin
      a_ready  = 1'b0;
      d_valid  = 1'($urandom_range(0, 1));
      d_opcode = 4'($urandom);
      d_data   = $urandom;
      tick();
      chk("a_hold_valid", 32'(a_valid), 32'd1);
      chk("a_hold_opcode", 32'(a_opcode), 32'(e_op));
      chk("a_hold_address", 32'(a_address), 32'(e_addr));
    end
    d_valid = 1'b0;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("a_valid_fall", 32'(a_valid), 32'd0);
    chk("a_fields_clear", {a_data[27:0], a_opcode}, 32'd0);
    chk("d_ready_rise", 32'(d_ready), 32'd1);
    if (drop) begin
      req_wr[who] = 1'b0;
      req_rd[who] = 1'b0;
    end
    e_cyc = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
    cyc = 0;
    while (rsp_v == 2'b00 && cyc < 300) begin
      d_valid  = (cyc == lat);
      d_opcode = d_op;
      d_data   = d_dat;
      tick();
      d_valid = 1'b0;
      cyc++;
    end
    chk("rsp_latency", 32'(cyc), 32'(e_cyc));
    chk("rsp_v", 32'(rsp_v), (who == 0) ? 32'd1 : 32'd2);
    chk("rsp_data", rsp_data, e_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("d_ready_fall", 32'(d_ready), 32'd0);
    req_wr[who] = 1'b0;
    req_rd[who] = 1'b0;
    tick();
    chk("rsp_v_pulse", 32'(rsp_v), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int owners[$];
    int times[$];
    int t;

    rst_n = 1'b0;
    req_wr = '0; req_rd = '0; req_byte = '0; req_addr = '0; req_wdata = '0;
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_data = '0;
    tick();
    tick();
    check_quiet("reset");
    chk("reset_a_opcode", {a_data[27:0], a_opcode}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_quiet("idle_no_req");

    // who wr rd byte addr wdata a_dly lat d_op d_dat e_op e_mask e_adata e_rdata e_err drop
    tbl[0] = '{0, 1, 0, 4'hF, 4'h3, 32'hDEADBEEF, 0, 0, 4'h0, 32'hAAAA5555,
               4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1, 0, 1, 4'hF, 4'h5, 32'h11112222, 2, 3, 4'h1, 32'h12345678,
               4'h4, 4'hF, 32'h0, 32'h12345678, 1'b0, 1'b0};
    tbl[2] = '{0, 1, 0, 4'h3, 4'hA, 32'hCAFEF00D, 1, 1, 4'h1, 32'h55555555,
               4'h1, 4'h3, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{1, 0, 1, 4'h0, 4'h7, 32'h0, 0, 1000, 4'h1, 32'h99999999,
               4'h4, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[4] = '{0, 0, 1, 4'h5, 4'h9, 32'h0, 0, TIMEOUT - 1, 4'h1, 32'h0BADF00D,
               4'h4, 4'h5, 32'h0, 32'h0BADF00D, 1'b0, 1'b0};
    tbl[5] = '{1, 1, 1, 4'hF, 4'h2, 32'h77778888, 0, 2, 4'h0, 32'h33333333,
               4'h0, 4'hF, 32'h77778888, 32'h0, 1'b0, 1'b1};
    tbl[6] = '{0, 0, 1, 4'hC, 4'hE, 32'h0, 3, 0, 4'h0, 32'h24682468,
               4'h4, 4'hC, 32'h0, 32'h24682468, 1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].who, tbl[i].wr, tbl[i].rd, tbl[i].byt, tbl[i].addr, tbl[i].wdata);
      run_txn(tbl[i].who, tbl[i].e_op, tbl[i].e_mask, tbl[i].addr, tbl[i].e_adata,
              tbl[i].a_dly, tbl[i].lat, tbl[i].d_op, tbl[i].d_dat, tbl[i].e_rdata,
              tbl[i].e_err, tbl[i].drop);
    end

    // Asynchronous reset while waiting on D abandons the transaction
    set_req(1, 1'b0, 1'b1, 4'hF, 4'h6, 32'h0);
    tick();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    tick();
    tick();
    chk("pre_reset_d_ready", 32'(d_ready), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    req_wr = '0; req_rd = '0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b0, 1'b1, 4'hF, 4'h8, 32'h0);
    set_req(1, 1'b0, 1'b1, 4'hF, 4'h9, 32'h0);
    run_txn(0, 4'h4, 4'hF, 4'h8, 32'h0, 0, 0, 4'h1, 32'h13572468, 32'h13572468, 1'b0, 1'b0);
    req_rd = '0;
    tick();

    // Both reads held continuously with an instant slave: alternate, one per 4 cycles
    do_reset();
    set_req(0, 1'b0, 1'b1, 4'hF, 4'h1, 32'h0);
    set_req(1, 1'b0, 1'b1, 4'hF, 4'h2, 32'h0);
    a_ready = 1'b1; d_valid = 1'b1; d_opcode = 4'h1; d_data = 32'hFEEDFACE;
    t = 0;
    while (owners.size() < 4 && t < 60) begin
      tick();
      t++;
      if (rsp_v != 2'b00) begin
        owners.push_back((rsp_v == 2'b10) ? 1 : 0);
        times.push_back(t);
      end
    end
    req_rd = '0; a_ready = 1'b0; d_valid = 1'b0;
    chk("alt_count", 32'(owners.size()), 32'd4);
    for (int i = 0; i < owners.size(); i++) chk("alt_owner", 32'(owners[i]), 32'(i % 2));
    for (int i = 1; i < times.size(); i++) chk("alt_period", 32'(times[i] - times[i-1]), 32'd4);
    tick();
    chk("alt_idle", 32'(busy), 32'd0);
    mdl_last = 1;

    // Randomized transactions against a transaction-level model
    rq[0].act = 1'b0;
    rq[1].act = 1'b0;
    for (int n = 0; n < 60; n++) begin
      int          who, lat, adly, op;
      bit          get, tmo, drop;
      logic [3:0]  e_op, d_op;
      logic [31:0] e_adata, e_rdata, d_dat;
      logic        e_err;
      for (int i = 0; i < 2; i++) begin
        if (!rq[i].act && ($urandom_range(0, 2) != 0 || (i == 1 && !rq[0].act))) begin
          op        = $urandom_range(0, 2);
          rq[i].act = 1'b1;
          rq[i].wr  = (op != 1);
          rq[i].rd  = (op != 0);
          rq[i].byt = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
          rq[i].addr = 4'($urandom);
          rq[i].wd  = $urandom;
        end
        set_req(i, rq[i].act & rq[i].wr, rq[i].act & rq[i].rd, rq[i].byt, rq[i].addr, rq[i].wd);
      end
      if (rq[0].act && rq[1].act) who = (mdl_last == 1) ? 0 : 1;
      else who = rq[1].act ? 1 : 0;
      get     = !rq[who].wr;
      e_op    = get ? 4'h4 : ((rq[who].byt == 4'hF) ? 4'h0 : 4'h1);
      e_adata = get ? 32'h0 : rq[who].wd;
      lat     = $urandom_range(0, TIMEOUT + 2);
      adly    = $urandom_range(0, 3);
      drop    = ($urandom_range(0, 3) == 0);
      tmo     = (lat >= TIMEOUT);
      d_dat   = $urandom;
      d_op    = $urandom_range(0, 1) ? (get ? 4'h1 : 4'h0) : 4'($urandom);
      e_err   = tmo ? 1'b1 : (d_op != (get ? 4'h1 : 4'h0));
      e_rdata = (tmo || !get) ? 32'h0 : d_dat;
      run_txn(who, e_op, rq[who].byt, rq[who].addr, e_adata, adly, lat, d_op, d_dat,
              e_rdata, e_err, drop);
      rq[who].act = 1'b0;
      mdl_last    = who;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
